load_store_unit: RTL and testbench

- Sits directly upstream of the word-addressed data memory.
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake and drives the memory address, write data and write enable.
- Performs read-modify-write for byte and halfword stores, and extracts and sign/zero-extends load data.
- Returns one response per request, with an error flag for misaligned, reserved-size or out-of-range accesses.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t IDLE = 2'd0;
  localparam lsu_state_t RD   = 2'd1;
  localparam lsu_state_t WR   = 2'd2;
  localparam lsu_state_t RESP = 2'd3;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: is_misaligned = lo[0];
      SZ_WORD: is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: merges sub-word store data into an old word and
// extracts/extends load data. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic [WL-1:0] old_word,
  input  logic [WL-1:0] st_data,
  input  logic [1:0]    lane,
  input  logic [1:0]    size,
  input  logic          is_unsigned,
  output logic [WL-1:0] st_word,
  output logic [WL-1:0] ld_data
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_off = {lane, 3'b000};
  assign half_off = {lane[1], 4'b0000};
  assign ld_byte  = old_word[byte_off +: 8];
  assign ld_half  = old_word[half_off +: 16];

  always_comb begin
    st_word = old_word;
    ld_data = '0;
    case (size)
      SZ_BYTE: begin
        st_word[byte_off +: 8] = st_data[7:0];
        ld_data = {{(WL-8){~is_unsigned & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        st_word[half_off +: 16] = st_data[15:0];
        ld_data = {{(WL-16){~is_unsigned & ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        st_word = st_data;
        ld_data = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory,
// with read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | ready for a request
// RD    | memory word addressed; load result or merged store word captured
// WR    | single-cycle write strobe
// RESP  | response held until consumer accepts
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WL    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [WL-1:0] req_addr,
  input  logic [WL-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [WL-1:0] resp_rdata,
  output logic          resp_err,
  output logic [WL-1:0] mem_addr,
  output logic [WL-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [WL-1:0] mem_rdata
);

  lsu_state_t    state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic [WL-1:0] wdata_q, wdata_d;
  logic [WL-1:0] mem_addr_q, mem_addr_d;
  logic [WL-1:0] mem_wdata_q, mem_wdata_d;
  logic [WL-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic          accept;
  logic          req_err;
  logic [WL-1:0] req_index;
  logic [WL-1:0] merged_word;
  logic [WL-1:0] load_result;

  assign req_ready = rst_n & (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_index = {2'b00, req_addr[WL-1:2]};
  assign req_err   = (req_size == SZ_RSVD) | is_misaligned(req_size, req_addr[1:0])
                   | (req_index >= WL'(DEPTH));

  // Fed straight from memory so RD can capture both the merge and the load result.
  lsu_align #(.WL(WL)) u_align (
    .old_word    (mem_rdata),
    .st_data     (wdata_q),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .st_word     (merged_word),
    .ld_data     (load_result)
  );

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lane_d       = req_addr[1:0];
          size_d       = req_size;
          uns_d        = req_unsigned;
          we_d         = req_we;
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            mem_addr_d = req_index;
            if (req_we && req_size == SZ_WORD) begin
              mem_wdata_d = req_wdata;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (we_q) begin
          mem_wdata_d = merged_word;
          state_d     = WR;
        end else begin
          resp_rdata_d = load_result;
          state_d      = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_we     = (state_q == WR);
  assign resp_valid = (state_q == RESP);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:1023];
  int          wr_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int w0;

  load_store_unit #(.WL(32), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : '0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
      wr_cnt             <= wr_cnt + 1;
      last_waddr         <= mem_addr;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic accept_req(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int lat, input logic [31:0] rdata,
                           input logic err);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 20);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_rdata"}, resp_rdata, rdata);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, err});
  endtask

  task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input int lat, input logic [31:0] rdata, input logic err,
                      input int writes);
    int base;
    base = wr_cnt;
    drive_req(we, size, uns, addr, wdata);
    accept_req(tag);
    wait_resp(tag, lat, rdata, err);
    @(posedge clk);
    #1;
    chk({tag, "_writes"}, wr_cnt - base, writes);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"},  {31'b0, req_ready},  32'd0);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"},   {31'b0, resp_err},   32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_addr"},   mem_addr,   32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,  32'd0);
    chk({tag, "_mem_we"},     {31'b0, mem_we}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b1;
    #1;
    chk_reset_outs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", {31'b0, req_ready}, 32'd1);

    // word store then word load
    xfer("st_w",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
    chk("st_w_waddr", last_waddr, 32'd4);
    chk("st_w_mem", mem[4], 32'hDEADBEEF);
    xfer("ld_w",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

    // byte read-modify-write and byte loads
    poke(10'd4, 32'h11223344);
    xfer("st_b",  1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, 3, 32'h0, 1'b0, 1);
    chk("st_b_waddr", last_waddr, 32'd4);
    chk("st_b_mem", mem[4], 32'h11AA3344);
    xfer("ld_bs", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 0);
    xfer("ld_bu", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 2, 32'h000000AA, 1'b0, 0);
    xfer("ld_b3", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'h00000011, 1'b0, 0);
    xfer("ld_b0", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 32'h00000044, 1'b0, 0);

    // halfword lanes
    poke(10'd4, 32'h80017FFE);
    xfer("ld_hs_hi", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 32'hFFFF8001, 1'b0, 0);
    xfer("ld_hs_lo", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 32'h00007FFE, 1'b0, 0);
    xfer("ld_hu_hi", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 32'h00008001, 1'b0, 0);
    xfer("st_h",     1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 3, 32'h0, 1'b0, 1);
    chk("st_h_mem", mem[4], 32'h12347FFE);

    // errors: misaligned, reserved size, out of range
    xfer("err_mis",  1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 32'h0, 1'b1, 0);
    xfer("err_rsvd", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);
    xfer("err_oor",  1'b1, 2'b10, 1'b0, 32'h1000, 32'h5A5A5A5A, 1, 32'h0, 1'b1, 0);
    chk("err_maddr", mem_addr, 32'd4);
    chk("err_mem", mem[4], 32'h12347FFE);
    xfer("err_mis_w", 1'b1, 2'b10, 1'b0, 32'h16, 32'h0, 1, 32'h0, 1'b1, 0);

    // back-pressure on the response; second request must wait
    resp_ready = 1'b0;
    drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    accept_req("bp1");
    wait_resp("bp1", 2, 32'h12347FFE, 1'b0);
    drive_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_hold_rdata", resp_rdata, 32'h12347FFE);
      chk("bp_hold_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_valid", {31'b0, resp_valid}, 32'd0);
    chk("bp_after_ready", {31'b0, req_ready}, 32'd1);
    accept_req("bp2");
    wait_resp("bp2", 2, 32'h00000012, 1'b0);
    @(posedge clk);
    #1;

    // reset during the read phase of a byte store
    poke(10'd5, 32'h55667788);
    w0 = wr_cnt;
    drive_req(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000099);
    accept_req("rst_mid");
    chk("rst_mid_we_rd", {31'b0, mem_we}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_writes", wr_cnt - w0, 32'd0);
    chk("rst_mid_mem", mem[5], 32'h55667788);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    xfer("rst_ld", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'h55667788, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
